// File: rtl/lab3_sub_pkg.sv
// Shared constants for the serial nibble subtractor controller.
// State encoding and slice width used by the controller and bench.
package lab3_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_sub4.sv
// Combinational 4-bit borrow-lookahead subtractor slice.
// Computes D = X - Y - Bin with borrow-out Bout.
module nibble_sub4 (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       Bin,
    output logic [3:0] D,
    output logic       Bout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:1] w_b;

    // Generate borrow when 0-1; propagate incoming borrow when bits equal.
    assign w_g = ~X & Y;
    assign w_p = ~(X ^ Y);

    assign w_b[1] = w_g[0] | (w_p[0] & Bin);
    assign w_b[2] = w_g[1] | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & Bin);
    assign w_b[3] = w_g[2] | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Bin);
    assign Bout   = w_g[3] | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Bin);

    assign D = X ^ Y ^ {w_b, Bin};

endmodule

// File: rtl/lab3_serial_sub_ctrl.sv
// Serial multi-nibble subtractor: one 4-bit slice reused LSB nibble first.
// Optional SUB_ZERO_FLAG_EN adds a registered zero-result flag.
module lab3_serial_sub_ctrl
    import lab3_sub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] A,
    input  logic [NIBBLE_W*NIBBLES-1:0] B,
    input  logic                        Bin,
    output logic                        ready,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] D,
    output logic                        Bout
`ifdef SUB_ZERO_FLAG_EN
    , output logic                      zero
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_d;
    logic               r_borrow;
    logic               r_bout;
    logic [IDX_W-1:0]   r_idx;

    logic [NIBBLE_W-1:0] w_x;
    logic [NIBBLE_W-1:0] w_y;
    logic [NIBBLE_W-1:0] w_dn;
    logic                w_bo;

    assign w_x = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_y = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

    nibble_sub4 u_slice (
        .X    (w_x),
        .Y    (w_y),
        .Bin  (r_borrow),
        .D    (w_dn),
        .Bout (w_bo)
    );

`ifdef SUB_ZERO_FLAG_EN
    logic r_nz;
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nz   <= 1'b0;
            r_zero <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_nz <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_nz <= r_nz | (|w_dn);
            if (r_idx == LAST)
                r_zero <= ~(r_nz | (|w_dn));
        end
    end

    assign zero = r_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_idx    <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_d[r_idx*NIBBLE_W +: NIBBLE_W] <= w_dn;
                    r_borrow <= w_bo;
                    // idx holds on the last nibble so it never wraps.
                    if (r_idx == LAST) begin
                        r_bout  <= w_bo;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);
    assign D     = r_d;
    assign Bout  = r_bout;

endmodule

// File: tb/tb_lab3_serial_sub_ctrl.sv
// Self-checking bench: directed cases, abort, ignored start,
// exhaustive NIBBLES=1 sweep and random NIBBLES=4 back-to-back ops.
module tb_lab3_serial_sub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        s4;
    logic [15:0] a4, b4;
    logic        bin4;
    logic        ready4, busy4, done4;
    logic [15:0] d4;
    logic        bout4;

    logic        s1;
    logic [3:0]  a1, b1;
    logic        bin1;
    logic        ready1, busy1, done1;
    logic [3:0]  d1;
    logic        bout1;

`ifdef SUB_ZERO_FLAG_EN
    logic zero4, zero1;
`endif

    lab3_serial_sub_ctrl #(.NIBBLES(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (s4),
        .A     (a4),
        .B     (b4),
        .Bin   (bin4),
        .ready (ready4),
        .busy  (busy4),
        .done  (done4),
        .D     (d4),
        .Bout  (bout4)
`ifdef SUB_ZERO_FLAG_EN
        , .zero (zero4)
`endif
    );

    lab3_serial_sub_ctrl #(.NIBBLES(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (s1),
        .A     (a1),
        .B     (b1),
        .Bin   (bin1),
        .ready (ready1),
        .busy  (busy1),
        .done  (done1),
        .D     (d1),
        .Bout  (bout1)
`ifdef SUB_ZERO_FLAG_EN
        , .zero (zero1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready4();
        for (int i = 0; i < 50 && !ready4; i++) tick();
    endtask

    // Launch one op on the 4-nibble DUT and wait for done (bounded).
    task automatic do_op4(input logic [15:0] a, input logic [15:0] b,
                          input logic bin, output int lat);
        a4 = a; b4 = b; bin4 = bin; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        a4 = 16'($urandom); b4 = 16'($urandom); bin4 = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (done4) begin
                lat = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s4 = 1'b1; s1 = 1'b1;
        a4 = 16'hFFFF; b4 = 16'h0001; bin4 = 1'b1;
        a1 = 4'hF; b1 = 4'h1; bin1 = 1'b1;
        tick(); tick();
        n_vec++;
        if (ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl4 got r=%b b=%b d=%b want 1 0 0", ready4, busy4, done4);
        end
        n_vec++;
        if (d4 !== 16'h0 || bout4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out4 got D=%h Bout=%b want 0000 0", d4, bout4);
        end
        n_vec++;
        if (ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl1 got r=%b b=%b d=%b want 1 0 0", ready1, busy1, done1);
        end
        n_vec++;
        if (d1 !== 4'h0 || bout1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out1 got D=%h Bout=%b want 0 0", d1, bout1);
        end
`ifdef SUB_ZERO_FLAG_EN
        n_vec++;
        if (zero4 !== 1'b0 || zero1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_zero got %b %b want 0 0", zero4, zero1);
        end
`endif
        s4 = 1'b0; s1 = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [15:0] ta [3] = '{16'h1234, 16'h0000, 16'h8000};
        logic [15:0] tb [3] = '{16'h0234, 16'h0001, 16'h7FFF};
        logic        tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] td [3] = '{16'h1000, 16'hFFFF, 16'h0000};
        logic        te [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        for (int k = 0; k < 3; k++) begin
            wait_ready4();
            do_op4(ta[k], tb[k], tc[k], lat);
            n_vec++;
            if (lat !== 5) begin
                n_err++;
                $display("FAIL dir%0d_latency got %0d want 5", k, lat);
            end
            n_vec++;
            if (d4 !== td[k] || bout4 !== te[k]) begin
                n_err++;
                $display("FAIL dir%0d_result got D=%h Bout=%b want D=%h Bout=%b",
                         k, d4, bout4, td[k], te[k]);
            end
`ifdef SUB_ZERO_FLAG_EN
            n_vec++;
            if (zero4 !== (td[k] == 16'h0)) begin
                n_err++;
                $display("FAIL dir%0d_zero got %b want %b", k, zero4, td[k] == 16'h0);
            end
`endif
            tick();
            n_vec++;
            if (ready4 !== 1'b1 || d4 !== td[k]) begin
                n_err++;
                $display("FAIL dir%0d_after got ready=%b D=%h want 1 %h", k, ready4, d4, td[k]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        wait_ready4();
        a4 = 16'h1234; b4 = 16'h0234; bin4 = 1'b0; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        tick();
        a4 = 16'hFFFF; b4 = 16'h0000; bin4 = 1'b1; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        for (int i = 3; i <= 40; i++) begin
            if (done4) begin
                lat = i;
                break;
            end
            tick();
        end
        n_vec++;
        if (lat !== 5 || d4 !== 16'h1000 || bout4 !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_result got lat=%0d D=%h Bout=%b want 5 1000 0", lat, d4, bout4);
        end
        tick();
        n_vec++;
        if (ready4 !== 1'b1 || d4 !== 16'h1000) begin
            n_err++;
            $display("FAIL ignore_ready got ready=%b D=%h want 1 1000", ready4, d4);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        logic [15:0] ra, rb;
        logic rc;
        wait_ready4();
        a4 = 16'hFFFF; b4 = 16'h0001; bin4 = 1'b0; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if (ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0
            || d4 !== 16'h0 || bout4 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state got r=%b b=%b d=%b D=%h Bout=%b want 1 0 0 0000 0",
                     ready4, busy4, done4, d4, bout4);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done4) seen++;
            tick();
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_nodone got %0d done cycles want 0", seen);
        end
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        do_op4(ra, rb, rc, lat);
        n_vec++;
        if (lat !== 5 || d4 !== 16'(ra - rb - 16'(rc))
            || bout4 !== (17'(ra) < 17'(rb) + 17'(rc))) begin
            n_err++;
            $display("FAIL abort_next got lat=%0d D=%h Bout=%b want 5 %h %b", lat, d4, bout4,
                     16'(ra - rb - 16'(rc)), 17'(ra) < 17'(rb) + 17'(rc));
        end
    endtask

    // Exhaustive X,Y,Bin at NIBBLES=1 with start held high.
    task automatic test_sweep_n1();
        logic [4:0] q[$];
        logic [4:0] e;
        int idx = 0;
        int cyc = 0;
        int last_acc = -1;
        logic [8:0] v;
        while ((idx < 512 || q.size() > 0) && cyc < 5000) begin
            if (done1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL sweep_extra_done got done with empty queue");
                end else begin
                    e = q.pop_front();
                    if (d1 !== e[3:0] || bout1 !== e[4]
`ifdef SUB_ZERO_FLAG_EN
                        || zero1 !== (e[3:0] == 4'h0)
`endif
                    ) begin
                        n_err++;
                        $display("FAIL sweep_result got D=%h Bout=%b want D=%h Bout=%b",
                                 d1, bout1, e[3:0], e[4]);
                    end
                end
            end
            if (ready1) begin
                if (idx < 512) begin
                    if (last_acc >= 0) begin
                        n_vec++;
                        if (cyc - last_acc != 3) begin
                            n_err++;
                            $display("FAIL sweep_period got %0d want 3", cyc - last_acc);
                        end
                    end
                    last_acc = cyc;
                    v = 9'(idx);
                    a1 = v[3:0]; b1 = v[7:4]; bin1 = v[8];
                    e[3:0] = 4'(5'(a1) - 5'(b1) - 5'(bin1));
                    e[4]   = (5'(a1) < 5'(b1) + 5'(bin1));
                    q.push_back(e);
                    s1 = 1'b1;
                    idx++;
                end else begin
                    s1 = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        s1 = 1'b0;
        n_vec++;
        if (cyc >= 5000 || q.size() != 0) begin
            n_err++;
            $display("FAIL sweep_timeout got idx=%0d pending=%0d want 512 0", idx, q.size());
        end
    endtask

    // 1000 random ops at NIBBLES=4 with start held high.
    task automatic test_back_to_back_n4();
        logic [16:0] q[$];
        logic [16:0] e;
        int n = 0;
        int cyc = 0;
        int last_acc = -1;
        wait_ready4();
        while ((n < 1000 || q.size() > 0) && cyc < 10000) begin
            if (done4) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra_done got done with empty queue");
                end else begin
                    e = q.pop_front();
                    if (d4 !== e[15:0] || bout4 !== e[16]
`ifdef SUB_ZERO_FLAG_EN
                        || zero4 !== (e[15:0] == 16'h0)
`endif
                    ) begin
                        n_err++;
                        $display("FAIL b2b_result got D=%h Bout=%b want D=%h Bout=%b",
                                 d4, bout4, e[15:0], e[16]);
                    end
                end
            end
            if (ready4) begin
                if (n < 1000) begin
                    if (last_acc >= 0) begin
                        n_vec++;
                        if (cyc - last_acc != 6) begin
                            n_err++;
                            $display("FAIL b2b_period got %0d want 6", cyc - last_acc);
                        end
                    end
                    last_acc = cyc;
                    a4 = 16'($urandom); b4 = 16'($urandom); bin4 = 1'($urandom);
                    if (n % 97 == 0) b4 = a4;
                    e[15:0] = a4 - b4 - 16'(bin4);
                    e[16]   = (17'(a4) < 17'(b4) + 17'(bin4));
                    q.push_back(e);
                    s4 = 1'b1;
                    n++;
                end else begin
                    s4 = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        s4 = 1'b0;
        n_vec++;
        if (cyc >= 10000 || q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_timeout got n=%0d pending=%0d want 1000 0", n, q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        s4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        s1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_sweep_n1();
        test_back_to_back_n4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
